// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// opcodes, funct codes, ALU codes, FSM states and PC source selects.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_EQ   = 3'd6;
    localparam logic [2:0] ALU_GTZ  = 3'd7;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction classifier: op/funct to ALU code
// and instruction class flags; anything outside the set is illegal.
module instr_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 3
) (
    input  logic [5:0]          op_i,
    input  logic [5:0]          funct_i,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                is_rtype_o,
    output logic                is_load_o,
    output logic                is_store_o,
    output logic                is_branch_o,
    output logic                is_jump_o,
    output logic                illegal_o
);

    logic [2:0] code;

    // Classify the instruction and pick its ALU operation
    always_comb begin
        code        = ALU_PASS;
        is_rtype_o  = 1'b0;
        is_load_o   = 1'b0;
        is_store_o  = 1'b0;
        is_branch_o = 1'b0;
        is_jump_o   = 1'b0;
        illegal_o   = 1'b0;
        unique case (op_i)
            OP_RTYPE: begin
                is_rtype_o = 1'b1;
                unique case (funct_i)
                    FN_ADD:  code = ALU_ADD;
                    FN_SUB:  code = ALU_SUB;
                    FN_AND:  code = ALU_AND;
                    FN_OR:   code = ALU_OR;
                    FN_SLT:  code = ALU_SLT;
                    default: illegal_o = 1'b1;
                endcase
            end
            OP_ADDI: code = ALU_ADD;
            OP_ANDI: code = ALU_AND;
            OP_ORI:  code = ALU_OR;
            OP_LW: begin
                code      = ALU_ADD;
                is_load_o = 1'b1;
            end
            OP_SW: begin
                code       = ALU_ADD;
                is_store_o = 1'b1;
            end
            OP_BEQ: begin
                code        = ALU_EQ;
                is_branch_o = 1'b1;
            end
            OP_BGTZ: begin
                code        = ALU_GTZ;
                is_branch_o = 1'b1;
            end
            OP_J:    is_jump_o = 1'b1;
            default: illegal_o = 1'b1;
        endcase
    end

    assign alu_op_o = ALU_OP_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with a
// bus wait timer that traps on timeout or illegal instruction.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 3,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                mem_ready,
    input  logic                cond_true,
    output logic                bus_read,
    output logic                bus_write,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                i_or_r,
    output logic                reg_write,
    output logic                load,
    output logic                illegal,
    output logic [2:0]          state
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [5:0] op_q, funct_q;

    logic [5:0]          dec_op, dec_funct;
    logic [ALU_OP_W-1:0] d_alu;
    logic                d_rtype, d_load, d_store;
    logic                d_branch, d_jump, d_illegal;

    // DECODE acts on the live fields; later states use the latched copy
    assign dec_op    = (state_q == ST_DECODE) ? op    : op_q;
    assign dec_funct = (state_q == ST_DECODE) ? funct : funct_q;

    instr_decode #(
        .ALU_OP_W (ALU_OP_W)
    ) u_dec (
        .op_i        (dec_op),
        .funct_i     (dec_funct),
        .alu_op_o    (d_alu),
        .is_rtype_o  (d_rtype),
        .is_load_o   (d_load),
        .is_store_o  (d_store),
        .is_branch_o (d_branch),
        .is_jump_o   (d_jump),
        .illegal_o   (d_illegal)
    );

    // State, wait timer and instruction latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            timer_q <= '0;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (state_q == ST_DECODE) begin
                op_q    <= op;
                funct_q <= funct;
            end
        end
    end

    // Next state, wait timer and control outputs
    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_SEQ;
        alu_op    = '0;
        i_or_r    = 1'b0;
        reg_write = 1'b0;
        load      = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                bus_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (timer_q == TMO_LAST) begin
                    state_d = ST_TRAP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_DECODE: begin
                if (d_illegal) begin
                    state_d = ST_TRAP;
                end else if (d_jump) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op = d_alu;
                i_or_r = d_rtype;
                if (d_branch) begin
                    pc_write = cond_true;
                    pc_src   = PC_SRC_BRANCH;
                    state_d  = ST_FETCH;
                end else if (d_load || d_store) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                alu_op    = ALU_OP_W'(ALU_ADD);
                bus_read  = d_load;
                bus_write = d_store;
                if (mem_ready) begin
                    state_d = d_load ? ST_WB : ST_FETCH;
                end else if (timer_q == TMO_LAST) begin
                    state_d = ST_TRAP;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                i_or_r    = d_rtype;
                load      = d_load;
                state_d   = ST_FETCH;
            end
            ST_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench for multicycle_control: each instruction is expanded
// into its expected per-cycle output trace and compared every cycle.
module tb_multicycle_control;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       mem_ready, cond_true;
    logic       bus_read, bus_write, ir_write, pc_write;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       i_or_r, reg_write, load, illegal;
    logic [2:0] state;

    multicycle_control #(
        .ALU_OP_W (3),
        .TIMEOUT  (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct     (funct),
        .mem_ready (mem_ready),
        .cond_true (cond_true),
        .bus_read  (bus_read),
        .bus_write (bus_write),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_op    (alu_op),
        .i_or_r    (i_or_r),
        .reg_write (reg_write),
        .load      (load),
        .illegal   (illegal),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       br, bw, irw, pcw;
        logic [1:0] src;
        logic [2:0] alu;
        logic       ior, rw, ld, ill;
        logic       mr, cd, rs;
        logic [5:0] o, f;
    } rec_t;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3;
    localparam int K_BR = 4, K_J = 5, K_ILL = 6;

    rec_t q[$];
    rec_t cur;
    bit   cur_v = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rw_seen = 0;
    int   cyc = 0;

    logic [5:0] tops [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                              6'h08, 6'h0c, 6'h0d, 6'h23, 6'h2b,
                              6'h04, 6'h07, 6'h02};
    logic [5:0] tfns [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                              6'h00, 6'h00, 6'h00};

    function automatic int kind_of(logic [5:0] o, logic [5:0] f);
        case (o)
            6'h00: begin
                if (f == 6'h20 || f == 6'h22 || f == 6'h24 ||
                    f == 6'h25 || f == 6'h2a) return K_R;
                return K_ILL;
            end
            6'h08, 6'h0c, 6'h0d: return K_I;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h04, 6'h07: return K_BR;
            6'h02: return K_J;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(logic [5:0] o, logic [5:0] f);
        if (o == 6'h00) begin
            case (f)
                6'h20: return 3'd1;
                6'h22: return 3'd2;
                6'h24: return 3'd3;
                6'h25: return 3'd4;
                6'h2a: return 3'd5;
                default: return 3'd0;
            endcase
        end
        case (o)
            6'h08, 6'h23, 6'h2b: return 3'd1;
            6'h0c: return 3'd3;
            6'h0d: return 3'd4;
            6'h04: return 3'd6;
            6'h07: return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic rec_t mk(logic [2:0] st);
        rec_t r;
        r     = '0;
        r.st  = st;
        r.ill = (st == 3'd5);
        r.mr  = 1'($urandom);
        r.cd  = 1'($urandom);
        r.o   = 6'($urandom);
        r.f   = 6'($urandom);
        return r;
    endfunction

    function automatic logic [15:0] pack(rec_t r);
        return {r.st, r.br, r.bw, r.irw, r.pcw, r.src,
                r.alu, r.ior, r.rw, r.ld, r.ill};
    endfunction

    wire [15:0] got = {state, bus_read, bus_write, ir_write, pc_write,
                       pc_src, alu_op, i_or_r, reg_write, load, illegal};

    // Single compare point, mid-cycle, against the current expected record
    always @(negedge clk) begin
        if (cur_v) begin
            n_cmp++;
            if (got !== pack(cur)) begin
                n_bad++;
                $display("FAIL cycle%0d outputs: got %h required %h",
                         cyc, got, pack(cur));
            end
            if (reg_write === 1'b1) rw_seen++;
        end
    end

    task automatic pin(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // Expand one instruction into its cycle trace, then play it
    task automatic run(input logic [5:0] o, input logic [5:0] f,
                       input int wf, input int wm, input bit cond,
                       input int rst_mem, output int ncyc,
                       output int trap_at);
        rec_t r;
        int   k;
        bit   trapped;
        bit   done;
        trapped = 1'b0;
        done    = 1'b0;
        trap_at = -1;
        q.delete();
        k = kind_of(o, f);
        for (int i = 0; i < TO && i < wf; i++) begin
            r = mk(3'd0); r.br = 1'b1; r.mr = 1'b0;
            q.push_back(r);
        end
        if (wf >= TO) begin
            trapped = 1'b1;
        end else begin
            r = mk(3'd0); r.br = 1'b1; r.mr = 1'b1;
            r.irw = 1'b1; r.pcw = 1'b1;
            q.push_back(r);
            r = mk(3'd1); r.o = o; r.f = f;
            if (k == K_J) begin
                r.pcw = 1'b1; r.src = 2'd2;
            end
            q.push_back(r);
            if (k == K_ILL) begin
                trapped = 1'b1;
            end else if (k != K_J) begin
                r = mk(3'd2); r.alu = alu_of(o, f); r.ior = (k == K_R);
                if (k == K_BR) begin
                    r.cd = cond; r.pcw = cond; r.src = 2'd1;
                end
                q.push_back(r);
                if (k == K_LW || k == K_SW) begin
                    for (int i = 0; i < TO && i < wm && !done; i++) begin
                        r = mk(3'd3); r.alu = 3'd1; r.mr = 1'b0;
                        r.br = (k == K_LW); r.bw = (k == K_SW);
                        if (i == rst_mem) begin
                            r.rs = 1'b1; done = 1'b1;
                        end
                        q.push_back(r);
                    end
                    if (!done) begin
                        if (wm >= TO) begin
                            trapped = 1'b1;
                        end else begin
                            r = mk(3'd3); r.alu = 3'd1; r.mr = 1'b1;
                            r.br = (k == K_LW); r.bw = (k == K_SW);
                            q.push_back(r);
                        end
                    end
                end
                if (!done && !trapped && k != K_SW && k != K_BR) begin
                    r = mk(3'd4); r.rw = 1'b1;
                    r.ior = (k == K_R); r.ld = (k == K_LW);
                    q.push_back(r);
                end
            end
        end
        ncyc = q.size();
        if (trapped) begin
            trap_at = q.size();
            for (int i = 0; i < 20; i++) q.push_back(mk(3'd5));
            r = mk(3'd5); r.rs = 1'b1;
            q.push_back(r);
        end
        foreach (q[i]) begin
            rst       = q[i].rs;
            mem_ready = q[i].mr;
            cond_true = q[i].cd;
            op        = q[i].o;
            funct     = q[i].f;
            cur       = q[i];
            cur_v     = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int n, t, idx, wf, wm, rm;
        logic [5:0] o, f;
        rst       = 1'b1;
        op        = '0;
        funct     = '0;
        mem_ready = 1'b0;
        cond_true = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pin("reset_state", int'(state), 0);
        pin("reset_illegal", int'(illegal), 0);
        pin("reset_bus_read", int'(bus_read), 1);

        rw_seen = 0;
        run(6'h00, 6'h20, 0, 0, 1'b0, -1, n, t);
        pin("add_cycles", n, 4);
        pin("add_reg_write_pulses", rw_seen, 1);

        run(6'h23, 6'h11, 0, 3, 1'b0, -1, n, t);
        pin("lw_wait3_cycles", n, 8);

        run(6'h07, 6'h00, 0, 0, 1'b1, -1, n, t);
        pin("bgtz_taken_cycles", n, 3);
        run(6'h07, 6'h00, 0, 0, 1'b0, -1, n, t);
        pin("bgtz_not_taken_cycles", n, 3);

        run(6'h02, 6'h3f, 0, 0, 1'b0, -1, n, t);
        pin("j_cycles", n, 2);

        run(6'h2b, 6'h00, 0, 0, 1'b0, -1, n, t);
        pin("sw_cycles", n, 4);

        run(6'h3f, 6'h00, 0, 0, 1'b0, -1, n, t);
        pin("illegal_trap_index", t, 2);

        run(6'h00, 6'h20, 100, 0, 1'b0, -1, n, t);
        pin("fetch_timeout_trap_index", t, 16);

        run(6'h00, 6'h20, TO - 1, 0, 1'b0, -1, n, t);
        pin("fetch_last_cycle_ready_cycles", n, 19);

        run(6'h23, 6'h00, 0, 100, 1'b0, -1, n, t);
        pin("mem_timeout_trap_index", t, 19);

        run(6'h2b, 6'h00, 0, 5, 1'b0, 1, n, t);
        pin("sw_rst_mid_mem_cycles", n, 5);
        run(6'h00, 6'h22, 0, 0, 1'b0, -1, n, t);

        for (int i = 0; i < 200; i++) begin
            idx = int'($urandom_range(0, 13));
            if (idx == 13) begin
                o = 6'($urandom);
                f = 6'($urandom);
            end else begin
                o = tops[idx];
                f = (o == 6'h00) ? tfns[idx] : 6'($urandom);
            end
            wf = int'($urandom_range(0, 3));
            wm = int'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) wf = TO - 1;
            if ($urandom_range(0, 29) == 0) wf = TO;
            if ($urandom_range(0, 19) == 0) wm = TO - 1;
            if ($urandom_range(0, 29) == 0) wm = TO;
            rm = -1;
            if (wm > 0 && $urandom_range(0, 14) == 0)
                rm = int'($urandom_range(0, wm - 1));
            run(o, f, wf, wm, 1'($urandom), rm, n, t);
        end

        cur_v = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
